// File: rtl/cs_decode_ws.sv
// Chip-select decoder for the 68000 upper address bus: per-cycle latched selects,
// per-region wait states for a local Ready, unmapped-access bus-error timeout and boot overlay.
module cs_decode_ws #(
  parameter int          AW          = 24,
  parameter logic [3:0]  ROM_REGION  = 4'h4,
  parameter logic [15:0] IO_REGIONS  = 16'hFF20,
  parameter logic [3:0]  IACK_REGION = 4'hF,
  parameter int          ROM_WS      = 2,
  parameter int          RAM_WS      = 0,
  parameter int          TIMEOUT     = 64
) (
  input  logic          CLK,
  input  logic          nRES,
  input  logic [AW-9:0] A,
  input  logic          nWE,
  input  logic          CACT,
  output logic          ROMCS,
  output logic          RAMCS,
  output logic          VidRAMCSWR,
  output logic          SndRAMCSWR,
  output logic          IOCS,
  output logic          IACS,
  output logic          Ready,
  output logic          BERR,
  output logic          Overlay
);

  localparam logic [1:0] OVL = 2'd0;
  localparam logic [1:0] ARM = 2'd1;
  localparam logic [1:0] RUN = 2'd2;

  logic [1:0] ovl_state;
  logic       latched;
  logic       wait_on;
  logic       unmapped;
  logic [3:0] wcnt;
  logic [7:0] tcnt;

  logic       ovl_on;
  logic [3:0] region;
  logic       rom_hit, ram_hit, vid_hit, snd_hit, io_hit, iack_hit, unm_hit;

  // A is A[AW-1:8] of the CPU address, so CPU bit k sits at port bit k-8.
  assign ovl_on   = (ovl_state != RUN);
  assign region   = A[AW-9:AW-12];
  assign ram_hit  = ovl_on ? (A[AW-9:AW-11] == 3'b011) : (A[AW-9:AW-10] == 2'b00);
  assign rom_hit  = (region == ROM_REGION) || (ovl_on && (region == 4'h0));
  assign vid_hit  = ram_hit && (&A[AW-11:AW-16]) && !nWE;
  assign snd_hit  = vid_hit && ((A[7:0] == 8'hFE) || (A[7:0] == 8'hFF) ||
                                (A[7:0] == 8'hA2) || (A[7:0] == 8'hA3));
  assign iack_hit = (region == IACK_REGION);
  assign io_hit   = IO_REGIONS[region] || vid_hit;
  assign unm_hit  = !(rom_hit || ram_hit || io_hit || iack_hit);

  assign Overlay  = ovl_on;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      ROMCS      <= 1'b0;
      RAMCS      <= 1'b0;
      VidRAMCSWR <= 1'b0;
      SndRAMCSWR <= 1'b0;
      IOCS       <= 1'b0;
      IACS       <= 1'b0;
      Ready      <= 1'b0;
      BERR       <= 1'b0;
      latched    <= 1'b0;
      wait_on    <= 1'b0;
      unmapped   <= 1'b0;
      wcnt       <= 4'd0;
      tcnt       <= 8'd0;
      ovl_state  <= OVL;
    end else if (!CACT) begin
      ROMCS      <= 1'b0;
      RAMCS      <= 1'b0;
      VidRAMCSWR <= 1'b0;
      SndRAMCSWR <= 1'b0;
      IOCS       <= 1'b0;
      IACS       <= 1'b0;
      Ready      <= 1'b0;
      BERR       <= 1'b0;
      latched    <= 1'b0;
      wait_on    <= 1'b0;
      unmapped   <= 1'b0;
      if (ovl_state == ARM) ovl_state <= RUN;
    end else if (!latched) begin
      // Latching edge: capture every decode for the rest of the bus cycle.
      latched    <= 1'b1;
      ROMCS      <= rom_hit;
      RAMCS      <= ram_hit && !rom_hit;
      VidRAMCSWR <= vid_hit;
      SndRAMCSWR <= snd_hit;
      IOCS       <= io_hit;
      IACS       <= iack_hit;
      unmapped   <= unm_hit;
      tcnt       <= 8'd0;
      BERR       <= 1'b0;
      if (rom_hit) begin
        wait_on <= 1'b1;
        wcnt    <= 4'(ROM_WS);
        Ready   <= (ROM_WS == 0);
      end else if (ram_hit) begin
        wait_on <= 1'b1;
        wcnt    <= 4'(RAM_WS);
        Ready   <= (RAM_WS == 0);
      end else begin
        wait_on <= 1'b0;
        Ready   <= 1'b0;
      end
      if ((ovl_state == OVL) && (region == ROM_REGION)) ovl_state <= ARM;
    end else begin
      if (wait_on && !Ready) begin
        wcnt <= wcnt - 4'd1;
        if (wcnt == 4'd1) Ready <= 1'b1;
      end
      // Counter stops at TIMEOUT-1 once BERR is raised, so it never wraps.
      if (unmapped && !BERR) begin
        if (tcnt == 8'(TIMEOUT - 1)) BERR <= 1'b1;
        else                         tcnt <= tcnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cs_decode_ws.sv
// Directed bench for cs_decode_ws: table of bus cycles plus hand sequences for
// CACT glitch and mid-cycle reset.
module tb_cs_decode_ws;

  logic        CLK = 1'b0;
  logic        nRES;
  logic [15:0] A;
  logic        nWE;
  logic        CACT;
  logic        ROMCS, RAMCS, VidRAMCSWR, SndRAMCSWR, IOCS, IACS, Ready, BERR, Overlay;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  cs_decode_ws dut (
    .CLK(CLK), .nRES(nRES), .A(A), .nWE(nWE), .CACT(CACT),
    .ROMCS(ROMCS), .RAMCS(RAMCS), .VidRAMCSWR(VidRAMCSWR), .SndRAMCSWR(SndRAMCSWR),
    .IOCS(IOCS), .IACS(IACS), .Ready(Ready), .BERR(BERR), .Overlay(Overlay)
  );

  typedef struct {
    logic [23:0] addr;
    logic        nwe;
    int          hold;
    logic [5:0]  sel;     // {ROM,RAM,Vid,Snd,IO,IACK}
    int          rdy;     // clocks after latching edge, -1 = never
    int          berr;    // clocks after latching edge, -1 = never
    logic        ovl_in;
    logic        ovl_out;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [5:0] sels();
    return {ROMCS, RAMCS, VidRAMCSWR, SndRAMCSWR, IOCS, IACS};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cycle(input int idx, input vec_t v);
    int rl, bl;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge CLK);
    A = v.addr[23:8]; nWE = v.nwe; CACT = 1'b1;
    @(posedge CLK); #1;
    chk({tag, "_sel"}, int'(sels()), int'(v.sel));
    chk({tag, "_ovl_in"}, int'(Overlay), int'(v.ovl_in));
    rl = Ready ? 0 : -1;
    bl = BERR ? 0 : -1;
    A = ~v.addr[23:8];
    for (int k = 1; k < v.hold; k++) begin
      @(posedge CLK); #1;
      if (Ready && rl < 0) rl = k;
      if (BERR && bl < 0) bl = k;
    end
    chk({tag, "_sel_hold"}, int'(sels()), int'(v.sel));
    chk({tag, "_rdy_lat"}, rl, v.rdy);
    chk({tag, "_berr_lat"}, bl, v.berr);
    chk({tag, "_rdy_end"}, int'(Ready), (v.rdy >= 0) ? 1 : 0);
    chk({tag, "_berr_end"}, int'(BERR), (v.berr >= 0) ? 1 : 0);
    @(negedge CLK);
    CACT = 1'b0; nWE = 1'b1;
    @(posedge CLK); #1;
    chk({tag, "_clear"}, int'({sels(), Ready, BERR}), 0);
    chk({tag, "_ovl_out"}, int'(Overlay), int'(v.ovl_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{24'h000100, 1'b1, 5,  6'b100000,  2, -1, 1'b1, 1'b1};
    vecs[1]  = '{24'h600000, 1'b1, 5,  6'b010000,  0, -1, 1'b1, 1'b1};
    vecs[2]  = '{24'h400000, 1'b1, 5,  6'b100000,  2, -1, 1'b1, 1'b0};
    vecs[3]  = '{24'h000100, 1'b1, 5,  6'b010000,  0, -1, 1'b0, 1'b0};
    vecs[4]  = '{24'h3FFE00, 1'b0, 5,  6'b011110,  0, -1, 1'b0, 1'b0};
    vecs[5]  = '{24'h3F8000, 1'b0, 5,  6'b011010,  0, -1, 1'b0, 1'b0};
    vecs[6]  = '{24'h3FA200, 1'b0, 5,  6'b011110,  0, -1, 1'b0, 1'b0};
    vecs[7]  = '{24'h3FFE00, 1'b1, 5,  6'b010000,  0, -1, 1'b0, 1'b0};
    vecs[8]  = '{24'h600000, 1'b1, 70, 6'b000000, -1, 64, 1'b0, 1'b0};
    vecs[9]  = '{24'hE00000, 1'b1, 5,  6'b000010, -1, -1, 1'b0, 1'b0};
    vecs[10] = '{24'hF00000, 1'b1, 5,  6'b000011, -1, -1, 1'b0, 1'b0};
    vecs[11] = '{24'h500000, 1'b1, 5,  6'b000010, -1, -1, 1'b0, 1'b0};
    vecs[12] = '{24'h400000, 1'b1, 5,  6'b100000,  2, -1, 1'b0, 1'b0};

    nRES = 1'b0; A = 16'h0000; nWE = 1'b1; CACT = 1'b0;
    #1;
    chk("reset_outs", int'({sels(), Ready, BERR}), 0);
    chk("reset_ovl", int'(Overlay), 1);
    @(negedge CLK); @(negedge CLK);
    nRES = 1'b1;

    for (int i = 0; i < 13; i++) run_cycle(i, vecs[i]);

    // CACT drops and returns between two edges: the RAM cycle must stay latched.
    @(negedge CLK);
    A = 16'h0001; nWE = 1'b1; CACT = 1'b1;
    @(posedge CLK); #1;
    chk("glitch_first", int'(sels()), int'(6'b010000));
    @(negedge CLK);
    CACT = 1'b0; A = 16'hE000;
    #2 CACT = 1'b1;
    @(posedge CLK); #1;
    chk("glitch_hold_sel", int'(sels()), int'(6'b010000));
    chk("glitch_hold_rdy", int'(Ready), 1);
    @(negedge CLK); CACT = 1'b0;
    @(posedge CLK); #1;
    chk("glitch_clear", int'({sels(), Ready}), 0);
    @(negedge CLK); CACT = 1'b1;
    @(posedge CLK); #1;
    chk("glitch_new_cycle", int'(sels()), int'(6'b000010));
    @(negedge CLK); CACT = 1'b0;
    @(posedge CLK); #1;

    // Mid-cycle reset while the overlay FSM is in ARM.
    @(negedge CLK); nRES = 1'b0;
    #1 chk("rst2_ovl", int'(Overlay), 1);
    @(negedge CLK); nRES = 1'b1;
    @(negedge CLK);
    A = 16'h4000; CACT = 1'b1;
    @(posedge CLK); #1;
    chk("arm_rom", int'(sels()), int'(6'b100000));
    chk("arm_ovl", int'(Overlay), 1);
    @(posedge CLK); #3;
    nRES = 1'b0;
    #1;
    chk("midrst_outs", int'({sels(), Ready, BERR}), 0);
    chk("midrst_ovl", int'(Overlay), 1);
    CACT = 1'b0;
    @(negedge CLK); nRES = 1'b1;
    @(negedge CLK);
    A = 16'h0000; CACT = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_rom", int'(sels()), int'(6'b100000));
    chk("post_rst_ovl", int'(Overlay), 1);
    @(negedge CLK); CACT = 1'b0;
    @(posedge CLK); #1;
    chk("post_rst_clear", int'(sels()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cs_decode_ws.md
Name: cs_decode_ws

Overview:
- Parametrised successor to the FSB chip-select decoder.
- Decodes the 68000 upper address into the ROM, RAM, video/sound-RAM write, IO and IACK selects, and runs the boot overlay state machine.
- New over the previous generation: selects are latched per bus cycle and held until the cycle ends; per-region wait-state counters generate a local Ready; unmapped accesses time out to a bus error.
- Sits between the MC68HC000 bus interface (CACT cycle detect) and the memory/IOB controllers.

Parameters:
AW, 24, CPU address width; decoder uses A[AW-1:8], region = A[AW-1:AW-4]
ROM_REGION, 4'h4, region holding ROM; any access here disables the overlay
IO_REGIONS, 16'hFF20, bitmask of regions routed to IOB (bit n = region n; default 5,8-F)
IACK_REGION, 4'hF, interrupt-acknowledge region
ROM_WS, 2, ROM wait states (0..15)
RAM_WS, 0, RAM wait states (0..15)
TIMEOUT, 64, cycles before BERR on an unmapped access (2..255)

Ports:
CLK  in  1  bus clock
nRES  in  1  asynchronous active-low reset
A  in  AW-8  address A[AW-1:8]
nWE  in  1  write strobe, low = write
CACT  in  1  bus cycle active
ROMCS  out  1  ROM select (latched)
RAMCS  out  1  RAM select (latched)
VidRAMCSWR  out  1  write to top 64 KB of RAM window
SndRAMCSWR  out  1  write to sound buffer pages (xxFExx-xxFFxx, xxA2xx-xxA3xx of top 64 KB)
IOCS  out  1  IOB select, includes VidRAMCSWR
IACS  out  1  IACK select
Ready  out  1  local DTACK request for ROM/RAM cycles
BERR  out  1  bus error, unmapped access timeout
Overlay  out  1  1 = boot overlay active

Behaviour:
- Reset (nRES low, asynchronous, effective immediately, including mid-cycle):
  - all select outputs, Ready and BERR = 0; Overlay = 1; overlay FSM = OVL; counters = 0; cycle-latched flag cleared.
- Decode (combinational, from A, nWE, current overlay state):
  - RAM: overlay off → A[AW-1:AW-2]==00; overlay on → A[AW-1:AW-3]==011.
  - ROM: region==ROM_REGION, or overlay on and region==0.
  - VidRAMCSWR: RAM hit and A[AW-3:AW-8] all ones and nWE=0.
  - SndRAMCSWR: VidRAMCSWR and A[15:8] in {FE, FF, A2, A3}.
  - IACS: region==IACK_REGION.
  - IOCS: IO_REGIONS[region] or VidRAMCSWR.
  - Unmapped: none of ROM, RAM, IOCS, IACS.
- Cycle latch:
  - Latching edge = first posedge CLK with CACT=1 after CACT was 0.
  - At that edge, latch all decodes into the outputs; one-clock latency from CACT rise.
  - Outputs hold constant for the whole cycle regardless of A changes.
  - First posedge with CACT=0 clears all selects, Ready, BERR and the latched flag.
- Wait counter, on the latching edge:
  - ROM hit: load ROM_WS. RAM hit: load RAM_WS. Other cycles: Ready never asserts.
  - Load value 0: Ready asserts on the latching edge itself.
  - Otherwise decrement once per clock while CACT=1; Ready asserts on the edge where the count reaches 0.
  - Ready holds until CACT falls.
- Timeout counter (unmapped cycles only):
  - Cleared on the latching edge; increments each clock while CACT=1.
  - BERR asserts on the edge where the count equals TIMEOUT-1 and holds until CACT falls.
  - Counter saturates and does not wrap.
- Overlay FSM:
  - OVL: a latched cycle with region==ROM_REGION → ARM.
  - ARM: first posedge with CACT=0 → RUN.
  - RUN: terminal until reset.
  - Overlay = 1 in OVL and ARM. The disabling cycle and anything latched before CACT falls still decode with overlay on.
- Simultaneous events:
  - If CACT falls and rises between the same two edges (no CACT=0 edge seen), no new cycle is latched; the next cycle needs one CACT=0 edge.
  - An ARM→RUN transition and a clear happen on the same edge.
- No output is ever driven from an unlatched decode.

Test Plan:
1. Reset, then read A=000100 with CACT high → ROMCS=1 one clock later; Overlay=1; Ready after 2 further clocks (ROM_WS=2).
2. Read A=400000, CACT low, then read A=000100 → first cycle keeps Overlay=1; after CACT falls Overlay=0; second cycle gives RAMCS=1 with Ready on the latching edge.
3. Overlay off, write A=3FFE00 with nWE=0 → RAMCS, VidRAMCSWR, SndRAMCSWR, IOCS all 1; Ready on the latching edge; write to 3F8000 → SndRAMCSWR=0.
4. Overlay off, read A=600000 held 70 clocks → no selects; BERR rises 64 clocks after the latching edge and clears when CACT falls.
5. Read A=E00000 → IOCS=1 and Ready stays 0; read A=F00000 → IACS=1 and IOCS=1.
6. Assert nRES mid-ROM cycle while in ARM → outputs 0 immediately, Overlay=1; the next A=000000 cycle selects ROM.
